// File: rtl/alu_acc_seq_pkg.sv
// Shared definitions for the accumulator/carry sequencer: opcodes, FSM states
// and the default datapath width.
package alu_acc_seq_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 4;
    localparam int unsigned OP_WIDTH       = 4;

    typedef enum logic [OP_WIDTH-1:0] {
        OP_NOP = 4'h0,
        OP_ADD = 4'h1,
        OP_SUB = 4'h2,
        OP_IAC = 4'h3,
        OP_DAC = 4'h4,
        OP_DAA = 4'h5,
        OP_CLB = 4'h6,
        OP_CLC = 4'h7,
        OP_STC = 4'h8,
        OP_CMC = 4'h9,
        OP_CMA = 4'hA,
        OP_RAL = 4'hB,
        OP_RAR = 4'hC,
        OP_TCC = 4'hD,
        OP_LD  = 4'hE,
        OP_RSV = 4'hF
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_P1   = 2'd1,
        ST_P2   = 2'd2
    } state_e;

    // Ops that need a second adder pass to fold in the carry/borrow term.
    function automatic logic is_two_pass(input op_e op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_add.sv
// Carry-in-less ripple adder built from BLOCK_WIDTH-bit blocks.
// Ports:
//   a, b   in   WORD_WIDTH  operands
//   sum    out  WORD_WIDTH  a + b modulo 2^WORD_WIDTH (combinational)
//   carry  out  1           carry out of the top block (combinational)
// WORD_WIDTH must be a multiple of BLOCK_WIDTH.
module alu_add #(
    parameter int unsigned WORD_WIDTH  = 4,
    parameter int unsigned BLOCK_WIDTH = 4
) (
    input  logic [WORD_WIDTH-1:0] a,
    input  logic [WORD_WIDTH-1:0] b,
    output logic [WORD_WIDTH-1:0] sum,
    output logic                  carry
);

    localparam int unsigned NUM_BLOCKS = WORD_WIDTH / BLOCK_WIDTH;

    logic [NUM_BLOCKS:0] blk_carry;

    assign blk_carry[0] = 1'b0;

    // Each block adds its slice plus the ripple carry from the block below.
    for (genvar g = 0; g < NUM_BLOCKS; g++) begin : g_blk
        logic [BLOCK_WIDTH:0] part;

        assign part = {1'b0, a[g*BLOCK_WIDTH +: BLOCK_WIDTH]}
                    + {1'b0, b[g*BLOCK_WIDTH +: BLOCK_WIDTH]}
                    + (BLOCK_WIDTH+1)'(blk_carry[g]);
        assign sum[g*BLOCK_WIDTH +: BLOCK_WIDTH] = part[BLOCK_WIDTH-1:0];
        assign blk_carry[g+1] = part[BLOCK_WIDTH];
    end

    assign carry = blk_carry[NUM_BLOCKS];

endmodule

// File: rtl/alu_acc_seq.sv
// Accumulator/carry sequencer: accepts one ALU op per handshake, sequences one
// or two passes through the shared adder and owns the ACC and CY registers.
// Ports:
//   clk       in   1   rising-edge clock
//   rst_n     in   1   asynchronous active-low reset
//   op_valid  in   1   op_code/op_data valid
//   op_ready  out  1   high only in IDLE
//   op_code   in   4   operation code
//   op_data   in   DW  register/immediate operand, captured at accept
//   acc_out   out  DW  accumulator register
//   cy_out    out  1   carry/link register
//   done      out  1   one-cycle pulse after ACC/CY are written
module alu_acc_seq
    import alu_acc_seq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic [OP_WIDTH-1:0]   op_code,
    input  logic [DATA_WIDTH-1:0] op_data,
    output logic [DATA_WIDTH-1:0] acc_out,
    output logic                  cy_out,
    output logic                  done
);

    state_e                state;
    op_e                   opr_code;
    logic [DATA_WIDTH-1:0] opr_data;
    logic [DATA_WIDTH-1:0] acc;
    logic                  cy;
    logic [DATA_WIDTH-1:0] tmp;
    logic                  c1;

    logic [DATA_WIDTH-1:0] add_a;
    logic [DATA_WIDTH-1:0] add_b;
    logic [DATA_WIDTH-1:0] add_sum;
    logic                  add_carry;
    logic                  daa_adjust;

    assign acc_out = acc;
    assign cy_out  = cy;

    // Decimal adjust is needed when the nibble is out of BCD range or CY is set.
    assign daa_adjust = (acc > DATA_WIDTH'(9)) || cy;

    alu_add #(
        .WORD_WIDTH  (DATA_WIDTH),
        .BLOCK_WIDTH (4)
    ) u_add (
        .a     (add_a),
        .b     (add_b),
        .sum   (add_sum),
        .carry (add_carry)
    );

    // Adder operand selection per state and op.
    always_comb begin
        add_a = acc;
        add_b = '0;
        case (state)
            ST_P1: begin
                case (opr_code)
                    OP_ADD:  add_b = opr_data;
                    OP_SUB:  add_b = ~opr_data;
                    OP_IAC:  add_b = DATA_WIDTH'(1);
                    OP_DAC:  add_b = '1;
                    OP_DAA:  add_b = DATA_WIDTH'(6);
                    default: add_b = '0;
                endcase
            end
            ST_P2: begin
                // CY=1 means "no borrow", so for SUB it supplies the two's-complement +1.
                add_a = tmp;
                add_b = DATA_WIDTH'(cy);
            end
            default: begin
                add_a = acc;
                add_b = '0;
            end
        endcase
    end

    // Sequencer FSM with architectural register writeback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            opr_code <= OP_NOP;
            opr_data <= '0;
            acc      <= '0;
            cy       <= 1'b0;
            tmp      <= '0;
            c1       <= 1'b0;
            done     <= 1'b0;
            op_ready <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (op_valid) begin
                        opr_code <= op_e'(op_code);
                        opr_data <= op_data;
                        state    <= ST_P1;
                        op_ready <= 1'b0;
                    end
                end
                ST_P1: begin
                    tmp <= add_sum;
                    c1  <= add_carry;
                    if (is_two_pass(opr_code)) begin
                        state <= ST_P2;
                    end else begin
                        state    <= ST_IDLE;
                        op_ready <= 1'b1;
                        done     <= 1'b1;
                        case (opr_code)
                            OP_IAC, OP_DAC: begin
                                acc <= add_sum;
                                cy  <= add_carry;
                            end
                            OP_DAA: begin
                                if (daa_adjust) begin
                                    acc <= add_sum;
                                    cy  <= cy | add_carry;
                                end
                            end
                            OP_CLB: begin
                                acc <= '0;
                                cy  <= 1'b0;
                            end
                            OP_CLC: cy <= 1'b0;
                            OP_STC: cy <= 1'b1;
                            OP_CMC: cy <= ~cy;
                            OP_CMA: acc <= ~acc;
                            OP_RAL: {cy, acc} <= {acc, cy};
                            OP_RAR: {acc, cy} <= {cy, acc};
                            OP_TCC: begin
                                acc <= DATA_WIDTH'(cy);
                                cy  <= 1'b0;
                            end
                            OP_LD:  acc <= opr_data;
                            default: ;
                        endcase
                    end
                end
                ST_P2: begin
                    acc      <= add_sum;
                    cy       <= c1 | add_carry;
                    state    <= ST_IDLE;
                    op_ready <= 1'b1;
                    done     <= 1'b1;
                end
                default: begin
                    state    <= ST_IDLE;
                    op_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_acc_seq.sv
// Self-checking bench for alu_acc_seq: a reference model pushes expected
// ACC/CY/latency at each accept; results are popped when done pulses.
module tb_alu_acc_seq;

    logic       clk;
    logic       rst_n;
    logic       op_valid;
    logic       op_ready;
    logic [3:0] op_code;
    logic [3:0] op_data;
    logic [3:0] acc_out;
    logic       cy_out;
    logic       done;

    typedef struct {
        logic [3:0] acc;
        logic       cy;
        int         lat;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] m_acc;
    logic       m_cy;
    int         checks;
    int         errors;

    alu_acc_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op_code  (op_code),
        .op_data  (op_data),
        .acc_out  (acc_out),
        .cy_out   (cy_out),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: returns {cy, acc} after applying one op.
    function automatic logic [4:0] model(input logic [3:0] code, input logic [3:0] data,
                                         input logic [3:0] acc, input logic cy);
        logic [4:0] s;
        logic [3:0] inv;
        inv = ~data;
        case (code)
            4'h1: begin s = {1'b0, acc} + {1'b0, data} + {4'b0, cy}; return s; end
            4'h2: begin s = {1'b0, acc} + {1'b0, inv} + {4'b0, cy}; return s; end
            4'h3: begin s = {1'b0, acc} + 5'd1; return s; end
            4'h4: begin s = {1'b0, acc} + 5'd15; return s; end
            4'h5: begin
                if (acc > 4'd9 || cy) begin
                    s = {1'b0, acc} + 5'd6;
                    return {cy | s[4], s[3:0]};
                end
                return {cy, acc};
            end
            4'h6: return 5'b0;
            4'h7: return {1'b0, acc};
            4'h8: return {1'b1, acc};
            4'h9: return {~cy, acc};
            4'hA: return {cy, ~acc};
            4'hB: return {acc, cy};
            4'hC: return {acc[0], cy, acc[3:1]};
            4'hD: return {1'b0, 3'b0, cy};
            4'hE: return {cy, data};
            default: return {cy, acc};
        endcase
    endfunction

    function automatic void push_expected(input logic [3:0] code, input logic [3:0] data);
        logic [4:0] r;
        exp_t       e;
        r      = model(code, data, m_acc, m_cy);
        m_acc  = r[3:0];
        m_cy   = r[4];
        e.acc  = m_acc;
        e.cy   = m_cy;
        e.lat  = (code == 4'h1 || code == 4'h2) ? 3 : 2;
        sb.push_back(e);
    endfunction

    // Issue one op, wait for done, compare latency and result.
    task automatic run_op(input logic [3:0] code, input logic [3:0] data, input string name);
        exp_t e;
        int   cyc;
        @(negedge clk);
        op_valid = 1'b1;
        op_code  = code;
        op_data  = data;
        cyc = 0;
        while (!op_ready && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (op_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready: got %b expected 1", name, op_ready);
        end
        push_expected(code, data);
        @(negedge clk);
        op_valid = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        e = sb.pop_front();
        checks++;
        if (cyc !== e.lat) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", name, cyc, e.lat);
        end
        checks++;
        if (acc_out !== e.acc) begin
            errors++;
            $display("FAIL %s acc: got %h expected %h", name, acc_out, e.acc);
        end
        checks++;
        if (cy_out !== e.cy) begin
            errors++;
            $display("FAIL %s cy: got %b expected %b", name, cy_out, e.cy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL %s done_pulse: got %b expected 0", name, done);
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        op_valid = 1'b0;
        op_code  = 4'h0;
        op_data  = 4'h0;
        m_acc    = 4'h0;
        m_cy     = 1'b0;
        #12;
        checks++;
        if ({acc_out, cy_out, op_ready, done} !== 7'b0000_0_1_0) begin
            errors++;
            $display("FAIL reset_state: got acc=%h cy=%b rdy=%b done=%b expected 0 0 1 0",
                     acc_out, cy_out, op_ready, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        run_op(4'hE, 4'h9, "ld9");
        run_op(4'h8, 4'h0, "stc");
        run_op(4'h1, 4'h7, "add_9_7_c1");
        run_op(4'h1, 4'hF, "add_1_f_c1");
    endtask

    task automatic test_sub();
        run_op(4'hE, 4'h5, "ld5");
        run_op(4'h8, 4'h0, "stc");
        run_op(4'h2, 4'h3, "sub_5_3");
        run_op(4'hE, 4'h3, "ld3");
        run_op(4'h8, 4'h0, "stc");
        run_op(4'h2, 4'h5, "sub_3_5");
        run_op(4'h2, 4'h0, "sub_borrow_in");
    endtask

    task automatic test_daa();
        run_op(4'hE, 4'hC, "ldc");
        run_op(4'h7, 4'h0, "clc");
        run_op(4'h5, 4'h0, "daa_c");
        run_op(4'hE, 4'h7, "ld7");
        run_op(4'h7, 4'h0, "clc");
        run_op(4'h5, 4'h0, "daa_7");
    endtask

    task automatic test_rotates();
        run_op(4'hE, 4'h9, "ld9");
        run_op(4'h7, 4'h0, "clc");
        run_op(4'hB, 4'h0, "ral");
        run_op(4'hC, 4'h0, "rar");
    endtask

    task automatic test_misc();
        run_op(4'h4, 4'h0, "dac_9");
        run_op(4'h6, 4'h0, "clb");
        run_op(4'h4, 4'h0, "dac_0");
        run_op(4'hA, 4'h0, "cma");
        run_op(4'h9, 4'h0, "cmc");
        run_op(4'hD, 4'h0, "tcc");
        run_op(4'h3, 4'h0, "iac");
        run_op(4'h0, 4'hA, "nop");
        run_op(4'hF, 4'h5, "rsv");
    endtask

    // op_valid held high across four IAC ops; every accept must be separated.
    task automatic test_back_to_back();
        exp_t e;
        int   accepts;
        int   dones;
        bit   prev_accept;
        run_op(4'hE, 4'hE, "ld_e");
        run_op(4'h7, 4'h0, "clc");
        @(negedge clk);
        op_valid    = 1'b1;
        op_code     = 4'h3;
        op_data     = 4'h0;
        accepts     = 0;
        dones       = 0;
        prev_accept = 1'b0;
        for (int cyc = 0; cyc < 40 && dones < 4; cyc++) begin
            if (done === 1'b1) begin
                dones++;
                e = sb.pop_front();
                checks++;
                if (acc_out !== e.acc || cy_out !== e.cy) begin
                    errors++;
                    $display("FAIL b2b_result%0d: got acc=%h cy=%b expected acc=%h cy=%b",
                             dones, acc_out, cy_out, e.acc, e.cy);
                end
            end
            if (prev_accept) begin
                checks++;
                if (op_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_ready_p1: got %b expected 0", op_ready);
                end
            end
            prev_accept = 1'b0;
            if (op_ready === 1'b1 && op_valid) begin
                push_expected(4'h3, 4'h0);
                accepts++;
                prev_accept = 1'b1;
            end
            @(posedge clk);
            #1;
            if (accepts == 4) op_valid = 1'b0;
            @(negedge clk);
        end
        op_valid = 1'b0;
        checks++;
        if (accepts !== 4 || dones !== 4) begin
            errors++;
            $display("FAIL b2b_count: got accepts=%0d dones=%0d expected 4 4", accepts, dones);
        end
        checks++;
        if (acc_out !== 4'h2 || cy_out !== 1'b0) begin
            errors++;
            $display("FAIL b2b_final: got acc=%h cy=%b expected acc=2 cy=0", acc_out, cy_out);
        end
    endtask

    // Reset asserted while an ADD sits in its second pass.
    task automatic test_reset_mid_op();
        run_op(4'hE, 4'h9, "ld9");
        run_op(4'h8, 4'h0, "stc");
        @(negedge clk);
        op_valid = 1'b1;
        op_code  = 4'h1;
        op_data  = 4'h7;
        @(negedge clk);
        op_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({acc_out, cy_out, op_ready, done} !== 7'b0000_0_1_0) begin
            errors++;
            $display("FAIL reset_mid_add: got acc=%h cy=%b rdy=%b done=%b expected 0 0 1 0",
                     acc_out, cy_out, op_ready, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_acc = 4'h0;
        m_cy  = 1'b0;
        sb.delete();
        run_op(4'h3, 4'h0, "iac_after_reset");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_add();
        test_sub();
        test_daa();
        test_rotates();
        test_misc();
        test_back_to_back();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
